// File: rtl/fifo_rr_drain.sv
// fifo_rr_drain: round-robin burst drain of CHANNELS show-ahead FIFOs into one
// registered valid/ready output stage tagged with the source channel.
module fifo_rr_drain #(
    parameter int CHANNELS = 4,
    parameter int CHW      = 2,
    parameter int WIDTH    = 16,
    parameter int BURST    = 4,
    parameter int BCW      = 3
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [CHANNELS-1:0]       fifo_empty,
    input  logic [CHANNELS*WIDTH-1:0] fifo_q,
    output logic [CHANNELS-1:0]       fifo_rdreq,
    input  logic [CHANNELS-1:0]       ch_enable,
    output logic [WIDTH-1:0]          out_data,
    output logic [CHW-1:0]            out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);
    typedef enum logic {IDLE, XFER} state_t;
    state_t state, next_state;
    logic [CHW-1:0] grant, last_grant, sel;
    logic [BCW-1:0] bcnt;
    logic [CHANNELS-1:0] req;
    logic load_ok, pop, burst_done;

    assign req        = ~fifo_empty & ch_enable;
    assign load_ok    = ~out_valid | out_ready;
    assign pop        = resetn && state == XFER && req[grant] && load_ok;
    assign burst_done = bcnt == BCW'(BURST - 1);

    // Scan from farthest to nearest so the channel right after last_grant wins.
    always_comb begin
        int idx;
        sel = last_grant;
        idx = 0;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % CHANNELS;
            if (req[idx]) sel = CHW'(idx);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state == IDLE) next_state = |req ? XFER : IDLE;
        else if (!req[grant] || (pop && burst_done)) next_state = IDLE;
    end

    always_comb begin
        fifo_rdreq = pop ? CHANNELS'(1) << grant : '0;
        busy       = resetn & (state == XFER | out_valid);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            grant      <= '0;
            last_grant <= CHW'(CHANNELS - 1);
            bcnt       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
        end else begin
            if (state == IDLE && |req) begin
                grant      <= sel;
                last_grant <= sel;
                bcnt       <= '0;
            end
            if (pop) begin
                out_data  <= fifo_q[int'(grant)*WIDTH +: WIDTH];
                out_chan  <= grant;
                out_valid <= 1'b1;
                bcnt      <= bcnt + BCW'(1);
            end else if (load_ok) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rr_drain.sv
// tb_fifo_rr_drain: FIFO models feed the drain scheduler; a transaction-level
// round-robin model fills a scoreboard checked by an output monitor.
module tb_fifo_rr_drain;
    localparam int CH = 4;
    localparam int W = 16;
    localparam int BURST = 4;

    logic clock = 1'b0;
    logic resetn;
    logic [CH-1:0] fifo_empty, fifo_rdreq, ch_enable;
    logic [CH*W-1:0] fifo_q;
    logic [W-1:0] out_data;
    logic [1:0] out_chan;
    logic out_valid, out_ready, busy;

    fifo_rr_drain #(.CHANNELS(CH), .CHW(2), .WIDTH(W), .BURST(BURST), .BCW(3)) dut (
        .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
        .fifo_rdreq(fifo_rdreq), .ch_enable(ch_enable), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    logic [W-1:0] mem [CH][64];
    logic [5:0] wp [CH] = '{default: '0};
    logic [5:0] rp [CH] = '{default: '0};
    logic [5:0] mrd [CH] = '{default: '0};
    logic [17:0] exp_q [$];
    int last_m = CH - 1;
    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b1;

    for (genvar g = 0; g < CH; g++) begin : g_fifo
        assign fifo_empty[g] = wp[g] == rp[g];
        assign fifo_q[g*W +: W] = mem[g][rp[g]];
    end

    always @(posedge clock)
        for (int i = 0; i < CH; i++)
            if (fifo_rdreq[i]) rp[i] <= rp[i] + 6'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        logic [17:0] e;
        if (!resetn) check("rdreq_in_reset", 32'(fifo_rdreq), 0);
        check("rdreq_onehot0", 32'($onehot0(fifo_rdreq)), 1);
        for (int i = 0; i < CH; i++)
            if (fifo_rdreq[i]) check("pop_nonempty", 32'(fifo_empty[i]), 0);
        if (resetn && mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {14'd0, out_chan, out_data}, 32'hdead);
            end else begin
                e = exp_q.pop_front();
                check("out_chan", 32'(out_chan), 32'(e[17:16]));
                check("out_data", 32'(out_data), 32'(e[15:0]));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int c, input logic [W-1:0] d);
        mem[c][wp[c]] = d;
        wp[c] = wp[c] + 6'd1;
    endtask

    // Transaction-level round robin: next enabled non-empty channel after the
    // last grant yields up to BURST words, repeated until nothing is eligible.
    task automatic model_drain(input logic [CH-1:0] en);
        bit more = 1'b1;
        while (more) begin
            int c = -1;
            int n = 0;
            for (int k = 1; k <= CH; k++) begin
                int j = (last_m + k) % CH;
                if (c < 0 && en[j] && wp[j] != mrd[j]) c = j;
            end
            if (c < 0) begin
                more = 1'b0;
            end else begin
                while (n < BURST && wp[c] != mrd[c]) begin
                    exp_q.push_back({2'(c), mem[c][mrd[c]]});
                    mrd[c] = mrd[c] + 6'd1;
                    n++;
                end
                last_m = c;
            end
        end
    endtask

    task automatic wait_drain(input bit rnd);
        bit done = 1'b0;
        int n = 0;
        while (!done && n < 3000) begin
            if (exp_q.size() == 0 && !busy) done = 1'b1;
            else begin
                step();
                if (rnd) out_ready = $urandom_range(0, 3) != 0;
                n++;
            end
        end
        check("drain_done", 32'(done), 1);
        out_ready = 1'b1;
    endtask

    task automatic wait_pops(input int c, input int want, output int got);
        int n = 0;
        got = 0;
        while (got < want && n < 30) begin
            if (fifo_rdreq[c]) got++;
            step();
            n++;
        end
    endtask

    initial begin
        int got;
        logic [13:0] pat;
        resetn = 1'b0;
        ch_enable = '1;
        out_ready = 1'b1;
        for (int i = 0; i < CH; i++) push(i, 16'h10 + 16'(i));
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_rdreq", 32'(fifo_rdreq), 0);
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_busy", 32'(busy), 0);
        end
        resetn = 1'b1;
        #1 check("t1_idle_first", 32'(fifo_rdreq), 0);
        last_m = CH - 1;
        model_drain(4'hf);
        step();
        check("t1_ch0_first", 32'(fifo_rdreq), 32'h1);
        wait_drain(0);

        for (int i = 0; i < 10; i++) push(2, 16'h20 + 16'(i));
        model_drain(4'hf);
        for (int n = 0; n < 10 && !fifo_rdreq[2]; n++) step();
        check("t2_start", 32'(fifo_rdreq[2]), 1);
        pat = '0;
        for (int i = 0; i < 14; i++) begin
            pat = {pat[12:0], fifo_rdreq[2]};
            step();
        end
        check("t2_pattern", 32'(pat), 32'(14'b11110111101100));
        wait_drain(0);

        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        last_m = CH - 1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 2; i++) begin
                push(0, 16'h100 + 16'(r*8 + i));
                push(1, 16'h110 + 16'(r*8 + i));
                push(3, 16'h130 + 16'(r*8 + i));
            end
            model_drain(4'hf);
            wait_drain(r == 1);
        end

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(1, 16'h1a0 + 16'(i));
        model_drain(4'hf);
        for (int n = 0; n < 10 && !out_valid; n++) step();
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_data", 32'(out_data), 32'h1a0);
            check("t4_stall_rdreq", 32'(fifo_rdreq), 0);
            step();
        end
        out_ready = 1'b1;
        #1 check("t4_resume_pop", 32'(fifo_rdreq), 32'h2);
        step();
        check("t4_word1", 32'(out_data), 32'h1a1);
        step();
        check("t4_word2", 32'(out_data), 32'h1a2);
        wait_drain(0);

        for (int i = 0; i < 4; i++) push(0, 16'h300 + 16'(i));
        for (int i = 0; i < 2; i++) push(1, 16'h310 + 16'(i));
        exp_q.push_back({2'd0, 16'h300});
        exp_q.push_back({2'd0, 16'h301});
        exp_q.push_back({2'd1, 16'h310});
        exp_q.push_back({2'd1, 16'h311});
        mrd[0] = mrd[0] + 6'd2;
        mrd[1] = mrd[1] + 6'd2;
        last_m = 1;
        wait_pops(0, 2, got);
        check("t5_two_pops", 32'(got), 2);
        ch_enable = 4'b1110;
        #1 check("t5_no_pop_after_mask", 32'(fifo_rdreq), 0);
        wait_drain(0);
        check("t5_ch0_left", 32'(wp[0] - rp[0]), 2);
        ch_enable = '1;
        model_drain(4'hf);
        wait_drain(0);

        mon_en = 1'b0;
        for (int i = 0; i < 5; i++) push(1, 16'h400 + 16'(i));
        wait_pops(1, 2, got);
        check("t6_two_pops", 32'(got), 2);
        check("t6_valid_before", 32'(out_valid), 1);
        resetn = 1'b0;
        #1 check("t6_rdreq_gated", 32'(fifo_rdreq), 0);
        push(0, 16'h500);
        step();
        check("t6_out_valid_cleared", 32'(out_valid), 0);
        check("t6_busy_cleared", 32'(busy), 0);
        resetn = 1'b1;
        #1 check("t6_idle_after_release", 32'(fifo_rdreq), 0);
        mrd[1] = rp[1];
        exp_q.delete();
        last_m = CH - 1;
        model_drain(4'hf);
        mon_en = 1'b1;
        step();
        check("t6_ch0_first", 32'(fifo_rdreq), 32'h1);
        wait_drain(0);

        for (int r = 0; r < 14; r++) begin
            ch_enable = (r == 13) ? 4'hf : 4'($urandom_range(1, 15));
            for (int c = 0; c < CH; c++)
                if (6'(wp[c] - rp[c]) < 6'd40)
                    for (int k = $urandom_range(0, 6); k > 0; k--) push(c, 16'($urandom));
            model_drain(ch_enable);
            wait_drain(1);
        end
        check("final_all_empty", 32'(fifo_empty), 32'hf);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
